pe_approx_sa_gen: RTL and testbench
===================================

# pe_approx_sa_gen

Parametrised processing element for the weight-stationary systolic array. Each cycle it multiplies a streamed signed activation by a locally held signed weight, adds the product to the partial sum arriving from above, and registers the result downward. The multiplier is selectable at run time: an exact product, or a leading-one approximate product with configurable mantissa width and fixed-point scaling. Double-buffered weights, a column shift chain and valid tagging let the array preload the next tile while the current one computes.

## Interface
- DW, 16: activation/weight width, signed two's complement
- PW, 16: partial-sum width, signed
- MB, 3: approximate-mode mantissa bits kept per operand, leading one included; 2 ≤ MB ≤ DW
- FRAC, 0: fixed-point scale; product magnitude is shifted right by FRAC before accumulation
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- act_in  in  DW  activation from west neighbour
- act_vld_in  in  1  act_in valid
- mode_in  in  1  0 = exact, 1 = approximate; sampled with act_in
- act_out  out  DW  registered activation to east neighbour
- act_vld_out  out  1  registered act_vld_in
- w_in  in  DW  weight shift-chain input from north
- w_shift  in  1  load shadow weight from w_in
- w_swap  in  1  copy shadow weight into active weight
- w_out  out  DW  shadow weight, feeds next PE's w_in
- psum_in  in  PW  partial sum from north
- psum_out  out  PW  registered partial sum to south
- psum_vld_out  out  1  psum_out valid

## Operation
- Registers: act_r, vld_r, mode_r, w_shadow, w_active, psum_r, psum_vld_r. All reset to 0. act_out = act_r, act_vld_out = vld_r, w_out = w_shadow, psum_out = psum_r, psum_vld_out = psum_vld_r.
- Each cycle: act_r ← act_in, vld_r ← act_vld_in, mode_r ← mode_in.
- w_shift = 1: w_shadow ← w_in. w_swap = 1: w_active ← w_shadow (old value). When both are asserted, w_active takes the old shadow and w_shadow takes w_in.
- Product P is computed from act_r and w_active:
  - Magnitudes |a| and |w| are unsigned DW bits. −2^(DW−1) maps to 2^(DW−1).
  - Sign s = a[DW−1] XOR w[DW−1].
  - If either operand is 0, P = 0.
- Exact mode: M = |a|·|w| (2·DW bits).
- Approximate mode:
  - i = index of the leading one. k = the MB bits starting at the leading one, zero-padded below bit 0 when i < MB−1.
  - M = (ka·kw) << (ia + iw − 2(MB−1)); a negative exponent is a right shift.
- Both modes: M' = M >> FRAC, truncating toward zero. P = s ? −M' : M', two's complement.
- When vld_r = 1: psum_r ← psum_in + P, psum_vld_r ← 1.
- When vld_r = 0: psum_r ← psum_in unchanged, psum_vld_r ← 0.
- Width rules depend on PE_SAT_EN (see Configuration).

## Timing
- act_in at edge t → act_out and act_vld_out at t+1.
- Product uses act_r at t+1 with psum_in present during cycle t+1 → psum_out at edge t+2.
- A weight swapped at edge t applies to products registered from edge t+1. Operands already in act_r see the new weight.
- w_shift at edge t → w_out updated at t+1. An N-deep column loads in N shift cycles, then one w_swap.
- No stalls. The PE is fully pipelined, one MAC per cycle.
- Reset mid-operation clears all registers immediately, including w_active and w_shadow. The weights must be reloaded afterwards.

## Configuration
- PE_SAT_EN defined:
  - P is clipped to [−2^(PW−1), 2^(PW−1)−1].
  - The sum psum_in + P is computed at PW+1 bits and clipped to the same range.
- PE_SAT_EN undefined:
  - P and the sum are truncated to their low PW bits, so both wrap modulo 2^PW.

## Test plan
Parameters DW=16, PW=16, MB=3, FRAC=0 unless stated.
- Reset, then hold rst low with no stimulus → all outputs 0. act_in=5 valid → act_out=5 and act_vld_out=1 one cycle later, psum_vld_out=1 one cycle after that.
- w=11 loaded via w_shift then w_swap, psum_in=0. act=13 approx → psum_out=120. act=−13 approx → −120. act=13 exact → 143. act=7, w=5 approx → 35.
- Double buffer: active w=2, shift shadow to 9 while streaming act=3 (out 6). Assert w_swap and w_shift together with w_in=4 → next product uses 9 (act=3 → 27), and w_out=4.
- Saturation: w=200, act=300 exact, psum_in=0 → 32767 with PE_SAT_EN, −5536 without. psum_in=−32768, act=−1, w=1 → −32768 with PE_SAT_EN, 32767 without.
- FRAC=4: act=100, w=3 exact → 18. act=−100 → −18. Zero operand in either mode → psum_out = psum_in.
- Invalid pass-through: act_vld_in=0, psum_in=1234 → psum_out=1234 and psum_vld_out=0 two cycles later. rst asserted mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/pe_approx_sa_gen_if.sv
// Bus bundle for one systolic-array processing element: activation stream
// (west -> east), weight shift chain (north -> south) and partial-sum path
// (north -> south). The array side drives through "master", the PE uses "slave".
interface pe_approx_sa_gen_if #(
    parameter int DW = 16,
    parameter int PW = 16
);
    logic [DW-1:0] act_in;
    logic          act_vld_in;
    logic          mode_in;
    logic [DW-1:0] act_out;
    logic          act_vld_out;
    logic [DW-1:0] w_in;
    logic          w_shift;
    logic          w_swap;
    logic [DW-1:0] w_out;
    logic [PW-1:0] psum_in;
    logic [PW-1:0] psum_out;
    logic          psum_vld_out;

    modport master (
        output act_in, act_vld_in, mode_in, w_in, w_shift, w_swap, psum_in,
        input  act_out, act_vld_out, w_out, psum_out, psum_vld_out
    );

    modport slave (
        input  act_in, act_vld_in, mode_in, w_in, w_shift, w_swap, psum_in,
        output act_out, act_vld_out, w_out, psum_out, psum_vld_out
    );
endinterface

// File: rtl/pe_approx_sa_gen.sv
// Weight-stationary systolic-array PE with run-time selectable exact or
// leading-one approximate multiplier, double-buffered weights and valid tagging.
// Optional feature macro: PE_SAT_EN -- when defined, the product and the
// accumulation saturate to the PW-bit signed range; otherwise both wrap.
module pe_approx_sa_gen #(
    parameter int DW   = 16,
    parameter int PW   = 16,
    parameter int MB   = 3,
    parameter int FRAC = 0
) (
    input logic                clk,
    input logic                rst,
    pe_approx_sa_gen_if.slave  bus
);

    localparam int MW = 2 * DW;
    localparam int XW = ((MW > PW) ? MW : PW) + 2;

    localparam logic [DW-1:0] ZERO_DW = {DW{1'b0}};
    localparam logic [PW-1:0] ZERO_PW = {PW{1'b0}};
    localparam logic [MW-1:0] ZERO_MW = {MW{1'b0}};
    localparam logic [DW-1:0] ONE_DW  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0] ONE_XW  = {{(XW-1){1'b0}}, 1'b1};

`ifdef PE_SAT_EN
    localparam logic [PW-1:0] PMAX_PW = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] PMIN_PW = {1'b1, {(PW-1){1'b0}}};
    localparam logic signed [XW-1:0] PMAX_X = $signed({{(XW-PW){1'b0}}, PMAX_PW});
    localparam logic signed [XW-1:0] PMIN_X = $signed({{(XW-PW){1'b1}}, PMIN_PW});
`endif

    // Unsigned magnitude of a two's-complement operand; the most negative
    // value maps onto 2^(DW-1), which still fits in DW unsigned bits.
    function automatic logic [DW-1:0] mag_f(input logic [DW-1:0] v);
        return v[DW-1] ? (~v + ONE_DW) : v;
    endfunction

    // Position of the most significant set bit (0 for a zero input).
    function automatic int lead_f(input logic [DW-1:0] v);
        int idx;
        idx = 0;
        for (int b = 0; b < DW; b++) begin
            idx = v[b] ? b : idx;
        end
        return idx;
    endfunction

    // MB-bit mantissa taken from the leading one down, zero-padded below
    // bit 0 when the operand is shorter than the mantissa.
    function automatic logic [MB-1:0] kbits_f(input logic [DW-1:0] v, input int idx);
        if (idx >= MB - 1) begin
            return MB'({{MB{1'b0}}, v} >> (idx - (MB - 1)));
        end else begin
            return MB'({{MB{1'b0}}, v} << ((MB - 1) - idx));
        end
    endfunction

    // Pipeline and weight registers.
    logic [DW-1:0] act_q, act_d;
    logic          vld_q, vld_d;
    logic          mode_q, mode_d;
    logic [DW-1:0] w_shadow_q, w_shadow_d;
    logic [DW-1:0] w_active_q, w_active_d;
    logic [PW-1:0] psum_q, psum_d;
    logic          psum_vld_q, psum_vld_d;

    // Datapath intermediates.
    logic [DW-1:0]   ma_s, mw_s;
    logic            neg_s, zero_s;
    int              ia_s, iw_s;
    logic [MB-1:0]   ka_s, kw_s;
    logic [2*MB-1:0] kprod_s;
    logic [MW-1:0]   exact_s, approx_s, mag_sel_s, mag_sc_s;
    logic [XW-1:0]   ext_s, p_u_s;
    logic [PW-1:0]   p_pw_s, sum_s;
`ifdef PE_SAT_EN
    logic signed [XW-1:0] p_full_s;
    logic [PW:0]          sum_x_s;
`endif

    // Operand magnitudes, product sign, zero detect and approximate mantissas.
    always_comb begin
        ma_s   = mag_f(act_q);
        mw_s   = mag_f(w_active_q);
        neg_s  = act_q[DW-1] ^ w_active_q[DW-1];
        zero_s = (ma_s == ZERO_DW) || (mw_s == ZERO_DW);
        ia_s   = lead_f(ma_s);
        iw_s   = lead_f(mw_s);
        ka_s   = kbits_f(ma_s, ia_s);
        kw_s   = kbits_f(mw_s, iw_s);
    end

    // Magnitude product (exact or approximate), scaled down and re-signed.
    always_comb begin
        exact_s  = {{DW{1'b0}}, ma_s} * {{DW{1'b0}}, mw_s};
        kprod_s  = {{MB{1'b0}}, ka_s} * {{MB{1'b0}}, kw_s};
        // Shift up by the full exponent first, then drop the 2(MB-1)
        // mantissa fraction bits, so a negative net exponent truncates.
        approx_s = MW'(({{MW{1'b0}}, kprod_s} << (ia_s + iw_s)) >> (2 * (MB - 1)));
        if (zero_s) begin
            mag_sel_s = ZERO_MW;
        end else if (mode_q) begin
            mag_sel_s = approx_s;
        end else begin
            mag_sel_s = exact_s;
        end
        mag_sc_s = mag_sel_s >> FRAC;
        ext_s    = {{(XW-MW){1'b0}}, mag_sc_s};
        p_u_s    = neg_s ? (~ext_s + ONE_XW) : ext_s;
    end

`ifdef PE_SAT_EN
    // Clip the product to PW bits, then add with one guard bit and clip again.
    always_comb begin
        p_full_s = $signed(p_u_s);
        if (p_full_s > PMAX_X) begin
            p_pw_s = PMAX_PW;
        end else if (p_full_s < PMIN_X) begin
            p_pw_s = PMIN_PW;
        end else begin
            p_pw_s = PW'(p_u_s);
        end
        sum_x_s = {bus.psum_in[PW-1], bus.psum_in} + {p_pw_s[PW-1], p_pw_s};
        if (sum_x_s[PW] != sum_x_s[PW-1]) begin
            sum_s = sum_x_s[PW] ? PMIN_PW : PMAX_PW;
        end else begin
            sum_s = sum_x_s[PW-1:0];
        end
    end
`else
    // Wrap-around accumulation: product and sum both taken modulo 2^PW.
    always_comb begin
        p_pw_s = PW'(p_u_s);
        sum_s  = bus.psum_in + p_pw_s;
    end
`endif

    // Next-state: activation pipeline, weight double buffer, partial sum.
    always_comb begin
        act_d      = bus.act_in;
        vld_d      = bus.act_vld_in;
        mode_d     = bus.mode_in;
        w_shadow_d = bus.w_shift ? bus.w_in : w_shadow_q;
        // Swap takes the shadow value from before this edge's shift.
        w_active_d = bus.w_swap ? w_shadow_q : w_active_q;
        if (vld_q) begin
            psum_d     = sum_s;
            psum_vld_d = 1'b1;
        end else begin
            psum_d     = bus.psum_in;
            psum_vld_d = 1'b0;
        end
    end

    // State registers; reset clears everything, weights included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q      <= ZERO_DW;
            vld_q      <= 1'b0;
            mode_q     <= 1'b0;
            w_shadow_q <= ZERO_DW;
            w_active_q <= ZERO_DW;
            psum_q     <= ZERO_PW;
            psum_vld_q <= 1'b0;
        end else begin
            act_q      <= act_d;
            vld_q      <= vld_d;
            mode_q     <= mode_d;
            w_shadow_q <= w_shadow_d;
            w_active_q <= w_active_d;
            psum_q     <= psum_d;
            psum_vld_q <= psum_vld_d;
        end
    end

    assign bus.act_out      = act_q;
    assign bus.act_vld_out  = vld_q;
    assign bus.w_out        = w_shadow_q;
    assign bus.psum_out     = psum_q;
    assign bus.psum_vld_out = psum_vld_q;

endmodule

// File: tb/tb_pe_approx_sa_gen.sv
// Bench for pe_approx_sa_gen: two PEs (FRAC=0 and FRAC=4) share one stimulus
// stream; an arithmetic reference model is compared every cycle, and
// hand-computed values pin the model at the interesting points.
module tb_pe_approx_sa_gen;

    localparam int DW = 16;
    localparam int PW = 16;
    localparam int MB = 3;
    localparam longint PMAX = 32767;
    localparam longint PMIN = -32768;

    logic clk;
    logic rst;

    logic [DW-1:0] act_in;
    logic          act_vld_in;
    logic          mode_in;
    logic [DW-1:0] w_in;
    logic          w_shift;
    logic          w_swap;
    logic [PW-1:0] psum_in;

    int checks;
    int failures;

    pe_approx_sa_gen_if #(.DW(DW), .PW(PW)) b0 ();
    pe_approx_sa_gen_if #(.DW(DW), .PW(PW)) b4 ();

    assign b0.act_in = act_in;  assign b4.act_in = act_in;
    assign b0.act_vld_in = act_vld_in;  assign b4.act_vld_in = act_vld_in;
    assign b0.mode_in = mode_in;  assign b4.mode_in = mode_in;
    assign b0.w_in = w_in;  assign b4.w_in = w_in;
    assign b0.w_shift = w_shift;  assign b4.w_shift = w_shift;
    assign b0.w_swap = w_swap;  assign b4.w_swap = w_swap;
    assign b0.psum_in = psum_in;  assign b4.psum_in = psum_in;

    pe_approx_sa_gen #(.DW(DW), .PW(PW), .MB(MB), .FRAC(0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    pe_approx_sa_gen #(.DW(DW), .PW(PW), .MB(MB), .FRAC(4)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int log2_floor(longint v);
        int e;
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        return e;
    endfunction

    function automatic longint mant(longint v, int e);
        if (e >= MB - 1) return v / (longint'(1) << (e - (MB - 1)));
        else return v * (longint'(1) << ((MB - 1) - e));
    endfunction

    function automatic longint model_p(logic [DW-1:0] a, logic [DW-1:0] w, bit approx, int frac);
        longint sa, sw, ma, mw, m, kp;
        int ea, ew, e;
        sa = longint'($signed(a));
        sw = longint'($signed(w));
        ma = (sa < 0) ? -sa : sa;
        mw = (sw < 0) ? -sw : sw;
        if (ma == 0 || mw == 0) return 0;
        if (approx) begin
            ea = log2_floor(ma);
            ew = log2_floor(mw);
            kp = mant(ma, ea) * mant(mw, ew);
            e  = ea + ew - 2 * (MB - 1);
            m  = (e >= 0) ? kp * (longint'(1) << e) : kp / (longint'(1) << (-e));
        end else begin
            m = ma * mw;
        end
        m = m / (longint'(1) << frac);
        return ((sa < 0) != (sw < 0)) ? -m : m;
    endfunction

    function automatic logic [PW-1:0] model_acc(logic [PW-1:0] ps, longint p);
        longint s;
        longint pc;
        pc = p;
`ifdef PE_SAT_EN
        if (pc > PMAX) pc = PMAX;
        if (pc < PMIN) pc = PMIN;
        s = longint'($signed(ps)) + pc;
        if (s > PMAX) s = PMAX;
        if (s < PMIN) s = PMIN;
`else
        s = longint'($signed(ps)) + pc;
`endif
        return PW'(s);
    endfunction

    logic [DW-1:0] m_act[2], m_wsh[2], m_wact[2];
    logic          m_vld[2], m_mode[2], m_pvld[2];
    logic [PW-1:0] m_psum[2];

    // Reference state update for both PE instances.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_act[i] <= '0; m_wsh[i] <= '0; m_wact[i] <= '0;
                m_vld[i] <= 1'b0; m_mode[i] <= 1'b0; m_pvld[i] <= 1'b0;
                m_psum[i] <= '0;
            end else begin
                m_act[i]  <= act_in;
                m_vld[i]  <= act_vld_in;
                m_mode[i] <= mode_in;
                m_wsh[i]  <= w_shift ? w_in : m_wsh[i];
                m_wact[i] <= w_swap ? m_wsh[i] : m_wact[i];
                m_pvld[i] <= m_vld[i];
                m_psum[i] <= m_vld[i]
                    ? model_acc(psum_in, model_p(m_act[i], m_wact[i], m_mode[i], (i == 0) ? 0 : 4))
                    : psum_in;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Every-cycle comparison of both PEs against the reference model.
    always @(negedge clk) begin
        chk("act_out0", int'(b0.act_out), int'(m_act[0]));
        chk("act_vld0", int'(b0.act_vld_out), int'(m_vld[0]));
        chk("w_out0", int'(b0.w_out), int'(m_wsh[0]));
        chk("psum0", int'($signed(b0.psum_out)), int'($signed(m_psum[0])));
        chk("psum_vld0", int'(b0.psum_vld_out), int'(m_pvld[0]));
        chk("act_out4", int'(b4.act_out), int'(m_act[1]));
        chk("act_vld4", int'(b4.act_vld_out), int'(m_vld[1]));
        chk("w_out4", int'(b4.w_out), int'(m_wsh[1]));
        chk("psum4", int'($signed(b4.psum_out)), int'($signed(m_psum[1])));
        chk("psum_vld4", int'(b4.psum_vld_out), int'(m_pvld[1]));
    end

    task automatic all_zero(input string nm);
        chk({nm, "_act0"}, int'(b0.act_out), 0);
        chk({nm, "_vld0"}, int'(b0.act_vld_out), 0);
        chk({nm, "_w0"}, int'(b0.w_out), 0);
        chk({nm, "_psum0"}, int'(b0.psum_out), 0);
        chk({nm, "_pvld0"}, int'(b0.psum_vld_out), 0);
        chk({nm, "_act4"}, int'(b4.act_out), 0);
        chk({nm, "_psum4"}, int'(b4.psum_out), 0);
        chk({nm, "_pvld4"}, int'(b4.psum_vld_out), 0);
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input int a, input bit v, input bit m, input int w,
                         input bit sh, input bit sw, input int ps);
        @(negedge clk);
        act_in = DW'(a); act_vld_in = v; mode_in = m;
        w_in = DW'(w); w_shift = sh; w_swap = sw; psum_in = PW'(ps);
    endtask

    task automatic load_w(input int w);
        drive(0, 1'b0, 1'b0, w, 1'b1, 1'b0, 0);
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 0);
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic mac(input string nm, input int a, input bit m, input int ps,
                       input int exp0, input bit chk4, input int exp4);
        drive(a, 1'b1, m, 0, 1'b0, 1'b0, ps);
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, ps);
        @(negedge clk);
        chk({nm, "_psum0"}, int'($signed(b0.psum_out)), exp0);
        chk({nm, "_pvld0"}, int'(b0.psum_vld_out), 1);
        if (chk4) chk({nm, "_psum4"}, int'($signed(b4.psum_out)), exp4);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1;
        act_in = '0; act_vld_in = 1'b0; mode_in = 1'b0;
        w_in = '0; w_shift = 1'b0; w_swap = 1'b0; psum_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Idle after reset, then first-activation latency.
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        all_zero("reset");
        act_in = DW'(5); act_vld_in = 1'b1;
        @(negedge clk);
        chk("lat_act_out", int'(b0.act_out), 5);
        chk("lat_act_vld", int'(b0.act_vld_out), 1);
        chk("lat_pvld_early", int'(b0.psum_vld_out), 0);
        act_in = '0; act_vld_in = 1'b0;
        @(negedge clk);
        chk("lat_pvld", int'(b0.psum_vld_out), 1);

        // Exact and approximate products.
        load_w(11);
        mac("ap_13", 13, 1'b1, 0, 120, 1'b0, 0);
        mac("ap_m13", -13, 1'b1, 0, -120, 1'b0, 0);
        mac("ex_13", 13, 1'b0, 0, 143, 1'b0, 0);
        load_w(5);
        mac("ap_7x5", 7, 1'b1, 0, 35, 1'b0, 0);
        mac("ap_psum", 7, 1'b1, 100, 135, 1'b0, 0);

        // Double buffer: shift while computing, then swap+shift together.
        load_w(2);
        drive(3, 1'b1, 1'b0, 9, 1'b1, 1'b0, 0);
        drive(3, 1'b1, 1'b0, 4, 1'b1, 1'b1, 0);
        @(negedge clk);
        chk("db_old_w", int'($signed(b0.psum_out)), 6);
        chk("db_w_out", int'(b0.w_out), 4);
        act_in = '0; act_vld_in = 1'b0; w_in = '0; w_shift = 1'b0; w_swap = 1'b0;
        @(negedge clk);
        chk("db_new_w", int'($signed(b0.psum_out)), 27);

        // Saturation / wrap boundaries.
        load_w(200);
`ifdef PE_SAT_EN
        mac("sat_pos", 300, 1'b0, 0, 32767, 1'b0, 0);
`else
        mac("wrap_pos", 300, 1'b0, 0, -5536, 1'b0, 0);
`endif
        load_w(1);
`ifdef PE_SAT_EN
        mac("sat_neg", -1, 1'b0, -32768, -32768, 1'b0, 0);
`else
        mac("wrap_neg", -1, 1'b0, -32768, 32767, 1'b0, 0);
`endif

        // FRAC=4 scaling and zero operands (both PEs).
        load_w(3);
        mac("frac_pos", 100, 1'b0, 0, 300, 1'b1, 18);
        mac("frac_neg", -100, 1'b0, 0, -300, 1'b1, -18);
        mac("zero_a_ex", 0, 1'b0, 77, 77, 1'b1, 77);
        mac("zero_a_ap", 0, 1'b1, 77, 77, 1'b1, 77);
        load_w(0);
        mac("zero_w_ap", 100, 1'b1, 77, 77, 1'b1, 77);

        // Invalid activation passes psum_in through untouched.
        drive(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1234);
        @(negedge clk);
        @(negedge clk);
        chk("inv_psum", int'($signed(b0.psum_out)), 1234);
        chk("inv_pvld", int'(b0.psum_vld_out), 0);

        // Asynchronous reset in the middle of a stream.
        load_w(7);
        drive(77, 1'b1, 1'b0, 5, 1'b1, 1'b0, 5);
        drive(78, 1'b1, 1'b0, 0, 1'b0, 1'b0, 5);
        #2;
        chk("pre_rst_act", int'(b0.act_out), 77);
        rst = 1'b1;
        #1;
        all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        act_in = '0; act_vld_in = 1'b0; psum_in = '0;
        @(negedge clk);
        all_zero("post_rst");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
